dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache with its miss FSM, in the MEM stage.
//  Takes MemRead/MemWrite, the ALU address, store data and byte enables from the MEM-stage latch.
//  cpu_stall is ORed into the pipeline freeze (write_pc/ifid/idex/exmem/memwb = 0).
//  Talks to main memory over a word-serial req/ack bus.
// PARAMETERS
//  INDEX_BITS   6    line index width: 2**INDEX_BITS lines
//  OFFS_BITS    2    word-in-line width: BLOCK_WORDS = 2**OFFS_BITS words of 32 bits
//  TAG_BITS     30-INDEX_BITS-OFFS_BITS (derived, not overridable)
// PORTS
//  clock       in   1   single clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  cpu_read    in   1   load in MEM stage
//  cpu_write   in   1   store in MEM stage
//  cpu_addr    in   32  byte address; [1:0] ignored, word aligned
//  cpu_wdata   in   32  store data, already lane-aligned
//  cpu_be      in   4   byte enables (SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111)
//  cpu_rdata   out  32  full load word, valid when access && !cpu_stall
//  cpu_stall   out  1   freeze pipeline
//  mem_req     out  1   word transfer request
//  mem_we      out  1   1 = write-back word, 0 = refill read
//  mem_addr    out  32  byte address of the word
//  mem_wdata   out  32  write-back data
//  mem_rdata   in   32  refill data, sampled when mem_ack
//  mem_ack     in   1   one word done this cycle; ignored if mem_req=0
//  hit_cnt     out  32  first-try hits, saturating
//  miss_cnt    out  32  misses, saturating
// BEHAVIOUR
//  Reset: state IDLE; all valid/dirty = 0; cnt, hit_cnt, miss_cnt = 0; mem_req/mem_we = 0.
//    cpu_stall = 0 unless an access is present. A reset mid-miss abandons the burst.
//    mem_req drops in the cycle after the reset edge. The half-filled line stays invalid.
//  access = cpu_read|cpu_write; both high: treated as write.
//  hit = valid[idx] && tag[idx]==addr[31:32-TAG_BITS]; idx = addr[OFFS_BITS+2 +: INDEX_BITS].
//  CPU inputs are held stable by the frozen pipeline while cpu_stall=1.
//  IDLE:
//    access&&hit: cpu_stall=0 combinationally, cpu_rdata = data[idx][word] combinationally.
//      Store writes the cpu_be bytes and sets dirty at the edge. Zero-cycle hit latency.
//    access&&!hit: cpu_stall=1 combinationally. miss_cnt++. cnt<=0.
//      Next state WB if valid&&dirty, else REFILL.
//    !access: stall 0, no state change.
//  WB: mem_req=1, mem_we=1, mem_addr={old_tag,idx,cnt,2'b00}, mem_wdata=data[idx][cnt].
//    On ack: cnt++. On ack with cnt==BLOCK_WORDS-1: cnt<=0, go to REFILL.
//  REFILL: mem_req=1, mem_we=0, mem_addr={new_tag,idx,cnt,2'b00}.
//    On ack: data[idx][cnt]<=mem_rdata, cnt++.
//    Last ack: tag<=new_tag, valid<=1, dirty<=0, go to DONE.
//  DONE: mem_req=0, cpu_stall=1 for one cycle, then IDLE.
//    IDLE re-looks up and hits. That hit does not bump hit_cnt (retry flag set in DONE, cleared in IDLE).
//  Any ack wait is allowed (0..n cycles); mem_req stays asserted and addr stays stable until ack.
//  Miss latency = 1 (detect) + WB words + REFILL words + 1 (DONE) + waits.
//  Counters stick at 32'hFFFF_FFFF.
//  Outputs other than cpu_rdata/cpu_stall are registered-state decodes (no input-to-mem comb path).
// STRUCTURE
//  Into include/constants.vh: DC_IDLE/DC_WB/DC_REFILL/DC_DONE 2-bit encodings.
//    Also the byte-enable patterns shared with control_mem_in.
//  Sub-module dcache_store: tag/valid/dirty/data arrays.
//    Async read, byte-enabled sync write, sync clear of valid/dirty on reset.
//  dcache_controller: FSM, word counter, address muxes, statistics.
// TESTING
//  Reset, then LW 0x100 -> stall, REFILL reads 0x100..0x10C, 4 acks.
//    Then DONE, then cpu_rdata=mem[0x100]; miss_cnt=1, hit_cnt=0.
//  Repeat LW 0x104 -> no stall, data in same cycle, hit_cnt=1, mem_req stays 0.
//  SB 0xAB at 0x101 (be=0010) -> hit.
//    LW 0x100 returns only byte1 changed; line dirty.
//  LW 0x4100 (same idx, other tag) -> WB writes 4 words to 0x100..0x10C with the SB byte.
//    Then REFILL from 0x4100.
//  Refill with ack delayed 3 cycles per word -> mem_addr held, stall held.
//    Total stall = 1+4*4+1.
//  Assert reset during REFILL word 2 -> next cycle mem_req=0, IDLE.
//    Re-read of same addr misses again.

Source files
------------

// File: rtl/dcache_controller_pkg.sv
// Shared types, encodings and helpers for the L1 data cache controller.
package dcache_controller_pkg;

    // Miss-handling FSM states.
    typedef enum logic [1:0] {
        DC_IDLE   = 2'b00,
        DC_WB     = 2'b01,
        DC_REFILL = 2'b10,
        DC_DONE   = 2'b11
    } dc_state_e;

    // Byte-enable patterns for lane 0 (shifted by the address low bits upstream).
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Increment that sticks at the all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_controller_store.sv
// Tag/valid/dirty/data arrays for the direct-mapped data cache.
// Two asynchronous read ports (CPU lookup, miss engine) and one write port.
module dcache_store
    import dcache_controller_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int OFFS_BITS  = 2,
    parameter int TAG_BITS   = 22
) (
    input  logic                  clock,
    input  logic                  reset,
    // Port A: CPU lookup
    input  logic [INDEX_BITS-1:0] a_idx,
    input  logic [OFFS_BITS-1:0]  a_word,
    output logic [TAG_BITS-1:0]   a_tag,
    output logic                  a_valid,
    output logic                  a_dirty,
    output logic [31:0]           a_data,
    // Port B: miss engine (write-back source)
    input  logic [INDEX_BITS-1:0] b_idx,
    input  logic [OFFS_BITS-1:0]  b_word,
    output logic [TAG_BITS-1:0]   b_tag,
    output logic [31:0]           b_data,
    // Write port
    input  logic                  w_en,
    input  logic [INDEX_BITS-1:0] w_idx,
    input  logic [OFFS_BITS-1:0]  w_word,
    input  logic [3:0]            w_be,
    input  logic [31:0]           w_data,
    input  logic                  set_dirty,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic                  inval_en,
    input  logic [INDEX_BITS-1:0] inval_idx
);

    localparam int LINES = 2 ** INDEX_BITS;
    localparam int WORDS = 2 ** OFFS_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][WORDS];
    logic [31:0]         wr_word_d;

    assign a_tag   = tag_q[a_idx];
    assign a_valid = valid_q[a_idx];
    assign a_dirty = dirty_q[a_idx];
    assign a_data  = data_q[a_idx][a_word];
    assign b_tag   = tag_q[b_idx];
    assign b_data  = data_q[b_idx][b_word];

    // Next line status: fill beats invalidate beats store-dirtying.
    always_comb begin
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        wr_word_d = merge_bytes(data_q[w_idx][w_word], w_data, w_be);
        for (int i = 0; i < LINES; i++) begin
            valid_d[i] = (fill_en && (w_idx == INDEX_BITS'(i))) ? 1'b1 :
                         (inval_en && (inval_idx == INDEX_BITS'(i))) ? 1'b0 :
                         valid_q[i];
            dirty_d[i] = (fill_en && (w_idx == INDEX_BITS'(i))) ? 1'b0 :
                         (inval_en && (inval_idx == INDEX_BITS'(i))) ? 1'b0 :
                         (set_dirty && (w_idx == INDEX_BITS'(i))) ? 1'b1 :
                         dirty_q[i];
        end
    end

    // Valid/dirty flags; reset invalidates every line.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays; writes are suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (!reset && fill_en) begin
            tag_q[w_idx] <= fill_tag;
        end
        if (!reset && w_en) begin
            data_q[w_idx][w_word] <= wr_word_d;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller (MEM stage).
// Hits complete in zero cycles; misses run WB (if dirty) -> REFILL -> DONE over a
// word-serial req/ack memory bus. Memory-side outputs decode registered state only.
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int OFFS_BITS  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_BITS = 30 - INDEX_BITS - OFFS_BITS;

    dc_state_e             state_q, state_d;
    logic [OFFS_BITS-1:0]  cnt_q, cnt_d;
    logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
    logic                  retry_q, retry_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    logic [TAG_BITS-1:0]   cpu_tag_s;
    logic [INDEX_BITS-1:0] cpu_idx_s;
    logic [OFFS_BITS-1:0]  cpu_word_s;
    logic                  access_s, hit_s, last_word_s;
    logic                  unused_addr_s;

    logic [TAG_BITS-1:0]   a_tag_s, b_tag_s;
    logic                  a_valid_s, a_dirty_s;
    logic [31:0]           a_data_s, b_data_s;
    logic                  w_en_s, set_dirty_s, fill_en_s, inval_en_s;
    logic [INDEX_BITS-1:0] w_idx_s;
    logic [OFFS_BITS-1:0]  w_word_s;
    logic [3:0]            w_be_s;
    logic [31:0]           w_data_s;

    assign cpu_tag_s     = cpu_addr[31 -: TAG_BITS];
    assign cpu_idx_s     = cpu_addr[OFFS_BITS+2 +: INDEX_BITS];
    assign cpu_word_s    = cpu_addr[2 +: OFFS_BITS];
    assign unused_addr_s = ^cpu_addr[1:0];
    assign access_s      = cpu_read | cpu_write;
    assign hit_s         = a_valid_s && (a_tag_s == cpu_tag_s);
    assign last_word_s   = (cnt_q == {OFFS_BITS{1'b1}});
    assign cpu_rdata     = a_data_s;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

    dcache_store #(
        .INDEX_BITS (INDEX_BITS),
        .OFFS_BITS  (OFFS_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clock     (clock),
        .reset     (reset),
        .a_idx     (cpu_idx_s),
        .a_word    (cpu_word_s),
        .a_tag     (a_tag_s),
        .a_valid   (a_valid_s),
        .a_dirty   (a_dirty_s),
        .a_data    (a_data_s),
        .b_idx     (miss_idx_q),
        .b_word    (cnt_q),
        .b_tag     (b_tag_s),
        .b_data    (b_data_s),
        .w_en      (w_en_s),
        .w_idx     (w_idx_s),
        .w_word    (w_word_s),
        .w_be      (w_be_s),
        .w_data    (w_data_s),
        .set_dirty (set_dirty_s),
        .fill_en   (fill_en_s),
        .fill_tag  (miss_tag_q),
        .inval_en  (inval_en_s),
        .inval_idx (cpu_idx_s)
    );

    // Next-state, bus outputs, store controls and statistics.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        retry_d     = retry_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        cpu_stall   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        w_en_s      = 1'b0;
        set_dirty_s = 1'b0;
        fill_en_s   = 1'b0;
        inval_en_s  = 1'b0;
        w_idx_s     = cpu_idx_s;
        w_word_s    = cpu_word_s;
        w_be_s      = cpu_be;
        w_data_s    = cpu_wdata;

        case (state_q)
            DC_IDLE: begin
                retry_d = 1'b0;
                if (access_s && hit_s) begin
                    if (cpu_write) begin
                        w_en_s      = 1'b1;
                        set_dirty_s = 1'b1;
                    end else begin
                        w_en_s      = 1'b0;
                    end
                    if (!retry_q) begin
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        hit_cnt_d = hit_cnt_q;
                    end
                end else if (access_s) begin
                    // Miss: latch the line address; the old line stops being valid.
                    cpu_stall  = 1'b1;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    cnt_d      = '0;
                    miss_tag_d = cpu_tag_s;
                    miss_idx_d = cpu_idx_s;
                    inval_en_s = 1'b1;
                    state_d    = (a_valid_s && a_dirty_s) ? DC_WB : DC_REFILL;
                end else begin
                    cpu_stall  = 1'b0;
                end
            end
            DC_WB: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {b_tag_s, miss_idx_q, cnt_q, 2'b00};
                mem_wdata = b_data_s;
                if (mem_ack) begin
                    cnt_d = cnt_q + OFFS_BITS'(1'b1);
                    if (last_word_s) begin
                        state_d = DC_REFILL;
                    end else begin
                        state_d = DC_WB;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DC_REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
                w_idx_s   = miss_idx_q;
                w_word_s  = cnt_q;
                w_be_s    = BE_WORD;
                w_data_s  = mem_rdata;
                if (mem_ack) begin
                    w_en_s = 1'b1;
                    cnt_d  = cnt_q + OFFS_BITS'(1'b1);
                    if (last_word_s) begin
                        fill_en_s = 1'b1;
                        state_d   = DC_DONE;
                    end else begin
                        state_d   = DC_REFILL;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DC_DONE: begin
                // One bubble so IDLE re-looks up the freshly filled line.
                cpu_stall = 1'b1;
                retry_d   = 1'b1;
                state_d   = DC_IDLE;
            end
            default: begin
                state_d = DC_IDLE;
            end
        endcase
    end

    // State, word counter, miss address and statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= DC_IDLE;
            cnt_q      <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            retry_q    <= 1'b0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            retry_q    <= retry_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: behavioural cache + memory model,
// a memory responder that checks every bus cycle, directed and random accesses.
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    always #5 clock = ~clock;

    dcache_controller dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural memory and cache model ----------------
    bit [31:0] gmem [bit [31:0]];

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        if (gmem.exists(a)) return gmem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit [31:0] bmerge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
        bit [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    bit        mv [64];
    bit        md [64];
    bit [21:0] mt [64];
    bit [31:0] ml [64][4];
    int        m_hits, m_misses;

    typedef struct { bit [31:0] addr; bit we; bit [31:0] data; } xact_t;
    xact_t expq[$];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
        m_hits = 0; m_misses = 0;
        expq.delete();
    endtask

    // Apply one CPU access to the model; queue the bus words a miss must produce.
    task automatic model_access(input bit wr, input bit [31:0] addr, input bit [31:0] wdata,
                                input bit [3:0] be, output bit hit, output int words);
        bit [5:0]  idx;
        bit [1:0]  w;
        bit [21:0] tg;
        xact_t     x;
        idx = addr[9:4]; w = addr[3:2]; tg = addr[31:10];
        words = 0;
        hit = mv[idx] && (mt[idx] == tg);
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            if (mv[idx] && md[idx]) begin
                for (int k = 0; k < 4; k++) begin
                    x.addr = {mt[idx], idx, 2'(k), 2'b00}; x.we = 1'b1; x.data = ml[idx][k];
                    expq.push_back(x); words++;
                end
            end
            for (int k = 0; k < 4; k++) begin
                x.addr = {tg, idx, 2'(k), 2'b00}; x.we = 1'b0; x.data = 32'd0;
                expq.push_back(x); words++;
                ml[idx][k] = mem_rd(x.addr);
            end
            mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tg;
        end
        if (wr) begin
            ml[idx][w] = bmerge(ml[idx][w], wdata, be);
            md[idx] = 1'b1;
        end
    endtask

    // ---------------- memory responder / per-cycle bus checker ----------------
    int dly_min = 0, dly_max = 0;
    int cur_delay = 0, wait_ctr = 0, waits_seen = 0;
    bit word_started = 1'b0;

    always @(negedge clock) begin
        if (reset || !mem_req) begin
            mem_ack = reset ? 1'b0 : 1'($urandom_range(1, 0));
            mem_rdata = $urandom;
            wait_ctr = 0;
            word_started = 1'b0;
        end else begin
            if (!word_started) begin
                cur_delay = $urandom_range(dly_max, dly_min);
                word_started = 1'b1;
            end
            if (expq.size() == 0) begin
                chk("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else begin
                chk("mem_addr", mem_addr, expq[0].addr);
                chk("mem_we", 32'(mem_we), 32'(expq[0].we));
                if (expq[0].we) chk("mem_wdata", mem_wdata, expq[0].data);
            end
            if (wait_ctr >= cur_delay) begin
                mem_ack = 1'b1;
                if (mem_we) gmem[mem_addr] = mem_wdata;
                else        mem_rdata = mem_rd(mem_addr);
                if (expq.size() > 0) void'(expq.pop_front());
                wait_ctr = 0;
                word_started = 1'b0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                wait_ctr++;
                waits_seen++;
            end
        end
    end

    // ---------------- CPU access driver ----------------
    int        last_stalls;
    bit [31:0] last_rdata;

    task automatic op(input bit rd, input bit wr, input bit [31:0] addr,
                      input bit [31:0] wdata, input bit [3:0] be);
        bit hit;
        int words, cyc, exp_stall;
        @(negedge clock);
        model_access(wr, addr, wdata, be, hit, words);
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        waits_seen = 0;
        #1;
        last_stalls = 0; cyc = 0;
        while (cpu_stall === 1'b1 && cyc < 300) begin
            last_stalls++;
            @(negedge clock); #1;
            cyc++;
        end
        if (cyc >= 300) chk("stall_timeout", 32'(cyc), 32'd0);
        exp_stall = hit ? 0 : (2 + words + waits_seen);
        chk("stall_cycles", 32'(last_stalls), 32'(exp_stall));
        last_rdata = cpu_rdata;
        if (rd && !wr) chk("cpu_rdata", cpu_rdata, ml[addr[9:4]][addr[3:2]]);
        @(posedge clock); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_misses));
        chk("bus_words_left", 32'(expq.size()), 32'd0);
        chk("mem_req_idle", 32'(mem_req), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock); #1;
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        repeat (n) @(negedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int cyc;
        bit [31:0] a, wd;
        bit [3:0]  be;
        bit [1:0]  sz;
        bit [1:0]  tsel, isel;
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_be = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        model_reset();
        gmem[32'h100] = 32'h1111_0000; gmem[32'h104] = 32'h2222_1111;
        gmem[32'h108] = 32'h3333_2222; gmem[32'h10C] = 32'h4444_3333;
        for (int i = 0; i < 4; i++) gmem[32'h4100 + 32'(4*i)] = 32'hA000_0000 + 32'(i);
        do_reset(3);
        #2;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);

        // Cold miss, then same-line hit.
        op(1'b1, 1'b0, 32'h100, 32'd0, BE_WORD);
        chk("lw100_data", 32'(last_rdata), 32'h1111_0000);
        chk("lw100_stall", 32'(last_stalls), 32'd6);
        chk("lw100_misses", miss_cnt, 32'd1);
        chk("lw100_hits", hit_cnt, 32'd0);
        op(1'b1, 1'b0, 32'h104, 32'd0, BE_WORD);
        chk("lw104_data", 32'(last_rdata), 32'h2222_1111);
        chk("lw104_stall", 32'(last_stalls), 32'd0);
        chk("lw104_hits", hit_cnt, 32'd1);

        // Byte store hit, then read back.
        op(1'b0, 1'b1, 32'h101, 32'h0000_AB00, BE_BYTE << 1);
        op(1'b1, 1'b0, 32'h100, 32'd0, BE_WORD);
        chk("sb_readback", 32'(last_rdata), 32'h1111_AB00);

        // Conflict miss with dirty victim: write-back then refill.
        op(1'b1, 1'b0, 32'h4100, 32'd0, BE_WORD);
        chk("wb_word0", mem_rd(32'h100), 32'h1111_AB00);
        chk("wb_word1", mem_rd(32'h104), 32'h2222_1111);
        chk("conflict_data", 32'(last_rdata), 32'hA000_0000);
        chk("conflict_stall", 32'(last_stalls), 32'd10);

        // Slow memory: 3 wait cycles per word.
        dly_min = 3; dly_max = 3;
        op(1'b1, 1'b0, 32'h300, 32'd0, BE_WORD);
        chk("slow_stall", 32'(last_stalls), 32'd18);

        // Reset in the middle of a refill.
        dly_min = 0; dly_max = 0;
        do_reset(1);
        @(negedge clock);
        begin
            bit h; int wds;
            model_access(1'b0, 32'h200, 32'd0, BE_WORD, h, wds);
        end
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h200; cpu_be = BE_WORD;
        cyc = 0;
        #1;
        while (!(mem_req === 1'b1 && mem_addr === 32'h208) && cyc < 50) begin
            @(negedge clock); #1; cyc++;
        end
        if (cyc >= 50) chk("midrefill_timeout", 32'(cyc), 32'd0);
        reset = 1'b1; cpu_read = 1'b0;
        @(posedge clock); #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(cpu_stall), 32'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        model_reset();
        op(1'b1, 1'b0, 32'h200, 32'd0, BE_WORD);
        chk("reread_misses", miss_cnt, 32'd1);
        chk("reread_stall", 32'(last_stalls), 32'd6);

        // Random traffic over a few conflicting lines.
        dly_min = 0; dly_max = 2;
        for (int n = 0; n < 300; n++) begin
            tsel = 2'($urandom_range(2, 0));
            isel = 2'($urandom_range(2, 0));
            a = (32'(tsel) << 10) | (32'(isel == 2'd2 ? 5 : isel) << 4) | (32'($urandom_range(3, 0)) << 2);
            sz = 2'($urandom_range(2, 0));
            if (sz == 2'd0) begin
                a[1:0] = 2'($urandom_range(3, 0)); be = BE_BYTE << a[1:0];
            end else if (sz == 2'd1) begin
                a[1:0] = 2'($urandom_range(1, 0)) << 1; be = BE_HALF << a[1:0];
            end else begin
                be = BE_WORD;
            end
            wd = $urandom;
            case ($urandom_range(5, 0))
                0, 1, 2: op(1'b1, 1'b0, a, wd, be);
                3, 4:    op(1'b0, 1'b1, a, wd, be);
                default: op(1'b1, 1'b1, a, wd, be);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
